alarm_ctrl: RTL
===============

# alarm_ctrl

Alarm stage directly downstream of the timekeeping block. Consumes the current BCD time digits and the 1 Hz `inc` tick, holds a user-settable alarm time (HH:MM), and raises `ringing`/`buzz` when the clock reaches HH:MM:00. Provides snooze, stop, and an automatic ring timeout. Its alarm digits feed the display mux alongside the clock digits.

## Interface
- `SNOOZE_SECS`, default 300: ticks spent in SNOOZE before re-ringing.
- `RING_SECS`, default 60: ticks in RING before automatic stop.
- `CNT_W`, default 9: tick counter width; must hold max(SNOOZE_SECS, RING_SECS)-1.

Ports:
- `clk` in 1: system clock; single clock domain.
- `resetn` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-cycle pulse per second; same signal as the seconds-counter `inc`.
- `secU`, `secT`, `minU`, `minT`, `hrU`, `hrT` in 4 each: current time digits in BCD.
- `alarm_enable` in 1: level; 0 disarms and cancels any ring or snooze.
- `set_alarm` in 1: level; 1 selects alarm-set mode.
- `select_pulse` in 1: debounced one-cycle pulse; rotates the digit selection.
- `increment_pulse` in 1: debounced one-cycle pulse; increments the selected digit.
- `snooze_pulse`, `stop_pulse` in 1 each: debounced one-cycle pulses.
- `almMinU`, `almMinT`, `almHrU`, `almHrT` out 4 each: stored alarm digits.
- `sel` out 4: one-hot digit selection {hrT, hrU, minT, minU}; 0 outside SET.
- `ringing` out 1: 1 in RING.
- `snoozing` out 1: 1 in SNOOZE.
- `buzz` out 1: 1 Hz on/off drive, valid only in RING.

## Operation
- States:
  - IDLE: armed if `alarm_enable` is 1.
  - SET: alarm digits are editable.
  - RING: alarm is sounding.
  - SNOOZE: ring is paused.
- Match logic:
  - `match_now` = (hrT,hrU,minT,minU equal the alarm digits) && secT==0 && secU==0.
  - `match_q` registers `match_now` every cycle in every state.
  - `fire` = `match_now` && !`match_q` && IDLE && `alarm_enable`.
- Transitions, in priority order:
  - Any state, `set_alarm`=1 → SET, with `sel`=0001 on entry.
  - SET, `set_alarm`=0 → IDLE.
  - RING or SNOOZE, `alarm_enable`=0 → IDLE.
  - RING, `stop_pulse` → IDLE. `stop_pulse` beats `snooze_pulse` when both arrive in the same cycle.
  - RING, `snooze_pulse` → SNOOZE.
  - RING, a tick while the count equals RING_SECS-1 → IDLE.
  - SNOOZE, `stop_pulse` → IDLE.
  - SNOOZE, a tick while the count equals SNOOZE_SECS-1 → RING.
  - IDLE, `fire` → RING.
- Tick counter:
  - Cleared on entry to RING and on entry to SNOOZE.
  - Increments on `tick_1hz` while in RING or SNOOZE.
- Buzz phase:
  - Set to 1 on RING entry; toggles on each tick while in RING.
  - `buzz` = phase && RING.
- SET mode:
  - `select_pulse` rotates `sel` in the order minU→minT→hrU→hrT→minU.
  - `increment_pulse` increments the selected digit.
  - When both pulses arrive in the same cycle, the increment applies to the currently selected digit and the rotation takes effect next cycle.
- Digit wrap rules:
  - minU: 9→0.
  - minT: 5→0.
  - hrT: 2→0. If hrT becomes 2 while hrU>3, hrU is forced to 0 in the same cycle.
  - hrU: wraps 9→0 when hrT<2; wraps 3→0 when hrT==2.
  - Wraps never carry into the neighbouring digit.
- Alarm digits change only in SET.

## Timing
- Reset values:
  - Alarm digits 0 (00:00); state IDLE; `sel`=0.
  - `ringing`, `snoozing`, `buzz`, `match_q`, tick counter, buzz phase all 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- `ringing` rises one cycle after the first cycle in which `match_now` is high.
- A match that persists across cycles fires only once. Leaving SET while a match is already active does not fire.
- Edits take effect one cycle after `increment_pulse`.
- Auto-stop occurs exactly RING_SECS ticks after RING entry. SNOOZE→RING occurs exactly SNOOZE_SECS ticks after SNOOZE entry.
- A tick in the same cycle as a state entry is not counted.
- Asserting `resetn` mid-ring or mid-snooze returns all state to reset values immediately.

## Structure
- Package `alarm_pkg` holds:
  - `alarm_state_t` enum (IDLE, SET, RING, SNOOZE).
  - Digit limit constants: MIN_U_MAX=9, MIN_T_MAX=5, HR_U_MAX=9, HR_U_MAX_AT_20=3, HR_T_MAX=2.
  - One-hot select constants.
- Sub-module `alarm_time_reg` holds the four alarm digits, the wrap/clamp rules and the `sel` rotation. The top level contains the FSM, match logic, counter and buzz logic.

## Test plan
- Reset, then in SET apply 7 increments with `sel`=hrU, then exit SET with `alarm_enable`=1 → alarm reads 07:00; drive time to 07:00:00 → `ringing`=1 one cycle later, and `buzz` toggles on each tick.
- RING with no input → `ringing` falls after exactly 60 ticks, and a persisting 07:00:00 match does not re-fire.
- RING, `snooze_pulse` → `snoozing`=1, `buzz`=0; after 300 ticks → `ringing`=1 again; `stop_pulse` → IDLE.
- `stop_pulse` and `snooze_pulse` in the same cycle during RING → IDLE; `snoozing` stays 0.
- Set hrU=9, then rotate to hrT and increment twice → hrT=2, hrU=0; a further hrU increment sequence 0→1→2→3→0.
- Assert `resetn` low during SNOOZE → all outputs 0 and alarm 00:00; `alarm_enable`=0 at a matching time → no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm stage: FSM states, BCD digit limits,
// one-hot digit-select codes and small helpers used by the digit editor.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SET    = 2'd1,
    RING   = 2'd2,
    SNOOZE = 2'd3
  } alarm_state_t;

  localparam logic [3:0] MIN_U_MAX      = 4'd9;
  localparam logic [3:0] MIN_T_MAX      = 4'd5;
  localparam logic [3:0] HR_U_MAX       = 4'd9;
  localparam logic [3:0] HR_U_MAX_AT_20 = 4'd3;
  localparam logic [3:0] HR_T_MAX       = 4'd2;

  // One-hot select, bit order {hrT, hrU, minT, minU}
  localparam logic [3:0] SEL_MIN_U = 4'b0001;
  localparam logic [3:0] SEL_MIN_T = 4'b0010;
  localparam logic [3:0] SEL_HR_U  = 4'b0100;
  localparam logic [3:0] SEL_HR_T  = 4'b1000;

  function automatic logic [3:0] wrapInc(input logic [3:0] d, input logic [3:0] maxVal);
    return (d >= maxVal) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] rotateSel(input logic [3:0] s);
    return {s[2:0], s[3]};
  endfunction

endpackage

// File: rtl/alarm_if.sv
// Bundle of time inputs, user controls and alarm outputs between the
// timekeeping/UI side (master) and the alarm stage (slave).
interface alarm_if;
  logic       tick_1hz;
  logic [3:0] secU, secT, minU, minT, hrU, hrT;
  logic       alarm_enable, set_alarm;
  logic       select_pulse, increment_pulse, snooze_pulse, stop_pulse;
  logic [3:0] almMinU, almMinT, almHrU, almHrT;
  logic [3:0] sel;
  logic       ringing, snoozing, buzz;

  modport master (
    output tick_1hz, secU, secT, minU, minT, hrU, hrT,
    output alarm_enable, set_alarm,
    output select_pulse, increment_pulse, snooze_pulse, stop_pulse,
    input  almMinU, almMinT, almHrU, almHrT, sel, ringing, snoozing, buzz
  );

  modport slave (
    input  tick_1hz, secU, secT, minU, minT, hrU, hrT,
    input  alarm_enable, set_alarm,
    input  select_pulse, increment_pulse, snooze_pulse, stop_pulse,
    output almMinU, almMinT, almHrU, almHrT, sel, ringing, snoozing, buzz
  );
endinterface

// File: rtl/alarm_time_reg.sv
// Stored alarm digits (HH:MM) with per-digit wrap rules, plus the one-hot
// digit selection that rotates while the alarm is being set.
module alarm_time_reg
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       inSet,
  input  logic       setNext,
  input  logic       selectPulse,
  input  logic       incrementPulse,
  output logic [3:0] minU,
  output logic [3:0] minT,
  output logic [3:0] hrU,
  output logic [3:0] hrT,
  output logic [3:0] sel
);

  logic [3:0] minUReg, minUNext;
  logic [3:0] minTReg, minTNext;
  logic [3:0] hrUReg, hrUNext;
  logic [3:0] hrTReg, hrTNext;
  logic [3:0] selReg, selNext;
  logic [3:0] digitHit;

  for (genvar gi = 0; gi < 4; gi++) begin : gHit
    assign digitHit[gi] = inSet && incrementPulse && selReg[gi];
  end

  always_comb begin
    minUNext = minUReg;
    minTNext = minTReg;
    hrUNext  = hrUReg;
    hrTNext  = hrTReg;
    if (digitHit[0]) minUNext = wrapInc(minUReg, MIN_U_MAX);
    if (digitHit[1]) minTNext = wrapInc(minTReg, MIN_T_MAX);
    if (digitHit[2]) hrUNext = wrapInc(hrUReg, (hrTReg == HR_T_MAX) ? HR_U_MAX_AT_20 : HR_U_MAX);
    if (digitHit[3]) begin
      hrTNext = wrapInc(hrTReg, HR_T_MAX);
      // Moving into the 20s must not leave an invalid hour such as 24..29
      if (hrTNext == HR_T_MAX && hrUReg > HR_U_MAX_AT_20) hrUNext = 4'd0;
    end
  end

  always_comb begin
    selNext = selReg;
    if (!setNext)         selNext = 4'd0;
    else if (!inSet)      selNext = SEL_MIN_U;
    else if (selectPulse) selNext = rotateSel(selReg);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      minUReg <= 4'd0;
      minTReg <= 4'd0;
      hrUReg  <= 4'd0;
      hrTReg  <= 4'd0;
      selReg  <= 4'd0;
    end else begin
      minUReg <= minUNext;
      minTReg <= minTNext;
      hrUReg  <= hrUNext;
      hrTReg  <= hrTNext;
      selReg  <= selNext;
    end
  end

  assign minU = minUReg;
  assign minT = minTReg;
  assign hrU  = hrUReg;
  assign hrT  = hrTReg;
  assign sel  = selReg;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm stage: compares current time with the stored alarm, runs the
// IDLE/SET/RING/SNOOZE state machine, tick counter and 1 Hz buzz phase.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SECS = 300,
  parameter int RING_SECS   = 60,
  parameter int CNT_W       = 9
) (
  input logic   clk,
  input logic   resetn,
  alarm_if.slave bus
);

  alarm_state_t stateReg, stateNext;
  logic             matchNow, matchQReg, fire;
  logic             ringDone, snoozeDone, enterCount;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic             phaseReg, phaseNext;
  logic [3:0]       almMinU, almMinT, almHrU, almHrT, selOut;

  alarm_time_reg uTimeReg (
    .clk           (clk),
    .resetn        (resetn),
    .inSet         (stateReg == SET),
    .setNext       (stateNext == SET),
    .selectPulse   (bus.select_pulse),
    .incrementPulse(bus.increment_pulse),
    .minU          (almMinU),
    .minT          (almMinT),
    .hrU           (almHrU),
    .hrT           (almHrT),
    .sel           (selOut)
  );

  assign matchNow = (bus.hrT == almHrT) && (bus.hrU == almHrU) &&
                    (bus.minT == almMinT) && (bus.minU == almMinU) &&
                    (bus.secT == 4'd0) && (bus.secU == 4'd0);
  // Rising edge of the match only, so a held 07:00:00 rings once
  assign fire       = matchNow && !matchQReg && (stateReg == IDLE) && bus.alarm_enable;
  assign ringDone   = bus.tick_1hz && (cntReg == CNT_W'(RING_SECS - 1));
  assign snoozeDone = bus.tick_1hz && (cntReg == CNT_W'(SNOOZE_SECS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stateReg <= IDLE;
    else         stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    if (bus.set_alarm) begin
      stateNext = SET;
    end else begin
      case (stateReg)
        SET:    stateNext = IDLE;
        RING: begin
          if (!bus.alarm_enable || bus.stop_pulse) stateNext = IDLE;
          else if (bus.snooze_pulse)               stateNext = SNOOZE;
          else if (ringDone)                       stateNext = IDLE;
        end
        SNOOZE: begin
          if (!bus.alarm_enable || bus.stop_pulse) stateNext = IDLE;
          else if (snoozeDone)                     stateNext = RING;
        end
        default: if (fire) stateNext = RING;
      endcase
    end
  end

  assign enterCount = (stateNext != stateReg) && ((stateNext == RING) || (stateNext == SNOOZE));

  always_comb begin
    cntNext = cntReg;
    if (enterCount)
      cntNext = '0;
    else if (((stateReg == RING) || (stateReg == SNOOZE)) && bus.tick_1hz)
      cntNext = cntReg + CNT_W'(1);
  end

  always_comb begin
    phaseNext = phaseReg;
    if (stateNext == RING && stateReg != RING) phaseNext = 1'b1;
    else if (stateReg == RING && bus.tick_1hz) phaseNext = ~phaseReg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      matchQReg <= 1'b0;
      cntReg    <= '0;
      phaseReg  <= 1'b0;
    end else begin
      matchQReg <= matchNow;
      cntReg    <= cntNext;
      phaseReg  <= phaseNext;
    end
  end

  always_comb begin
    bus.ringing  = (stateReg == RING);
    bus.snoozing = (stateReg == SNOOZE);
    bus.buzz     = phaseReg && (stateReg == RING);
  end

  assign bus.almMinU = almMinU;
  assign bus.almMinT = almMinT;
  assign bus.almHrU  = almHrU;
  assign bus.almHrT  = almHrT;
  assign bus.sel     = selOut;

endmodule
